pe_approx_sa: RTL and testbench

PE_APPROX_SA -- requirements
Module: pe_approx_sa

---
 rtl/pe_approx_sa_if.sv | 21 ++
 rtl/pe_approx_sa.sv | 98 +++++++++
 tb/tb_pe_approx_sa.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pe_approx_sa_if.sv
// Operand/result bundle of the approximate-multiply PE: activation, weight,
// incoming partial sum, combinational product and registered partial sum.
interface pe_approx_sa_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] ifmap;
  logic [DATA_W-1:0] weight;
  logic [DATA_W-1:0] ipsum;
  logic [DATA_W-1:0] approx_P;
  logic [DATA_W-1:0] approx_psum_reg;

  modport master (
    output ifmap, weight, ipsum,
    input  approx_P, approx_psum_reg
  );

  modport slave (
    input  ifmap, weight, ipsum,
    output approx_P, approx_psum_reg
  );
endinterface

// File: rtl/pe_approx_sa.sv
// Processing element with a Mitchell logarithmic multiplier on Q8.8 operands.
// The product is combinational; the saturated psum + product is registered.
module pe_approx_sa #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  pe_approx_sa_if.slave bus
);

  localparam int MAG_W = DATA_W + 1;
  localparam int LOG_W = $clog2(MAG_W);
  localparam int P_W   = 2 * DATA_W + 2;

  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [P_W-1:0]           LIM_V = P_W'(1) << (DATA_W - 1);

  function automatic logic [LOG_W-1:0] lod(input logic [MAG_W-1:0] v);
    logic [LOG_W-1:0] pos;
    pos = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (v[i]) pos = LOG_W'(i);
    end
    return pos;
  endfunction

  // Truncated magnitude back to signed range; -2^(DATA_W-1) is representable.
  function automatic logic signed [DATA_W-1:0] sat_prod(input logic neg,
                                                        input logic [P_W-1:0] m);
    logic signed [DATA_W-1:0] low;
    low = signed'(m[DATA_W-1:0]);
    if (!neg) return (m >= LIM_V) ? MAX_V : low;
    return (m >= LIM_V) ? MIN_V : -low;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] x,
                                                       input logic signed [DATA_W-1:0] y);
    logic signed [DATA_W:0] sum;
    sum = {x[DATA_W-1], x} + {y[DATA_W-1], y};
    if (sum[DATA_W] != sum[DATA_W-1]) return sum[DATA_W] ? MIN_V : MAX_V;
    return sum[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] ifmap_s;
  logic signed [DATA_W-1:0] weight_s;
  logic signed [DATA_W-1:0] ipsum_s;
  logic signed [MAG_W-1:0]  ifmap_x;
  logic signed [MAG_W-1:0]  weight_x;
  logic [MAG_W-1:0]         mag_a;
  logic [MAG_W-1:0]         mag_b;
  logic [LOG_W-1:0]         ka;
  logic [LOG_W-1:0]         kb;
  logic [LOG_W:0]           ksum;
  logic [MAG_W-1:0]         fa;
  logic [MAG_W-1:0]         fb;
  logic [P_W-1:0]           s_term;
  logic [P_W-1:0]           t_term;
  logic [P_W-1:0]           p_full;
  logic [P_W-1:0]           p_mag;
  logic                     neg;
  logic signed [DATA_W-1:0] prod_sat;
  logic signed [DATA_W-1:0] psum_p1;

  assign ifmap_s  = bus.ifmap;
  assign weight_s = bus.weight;
  assign ipsum_s  = bus.ipsum;

  always_comb begin
    ifmap_x  = {ifmap_s[DATA_W-1], ifmap_s};
    weight_x = {weight_s[DATA_W-1], weight_s};
    mag_a    = ifmap_s[DATA_W-1]  ? unsigned'(-ifmap_x)  : unsigned'(ifmap_x);
    mag_b    = weight_s[DATA_W-1] ? unsigned'(-weight_x) : unsigned'(weight_x);
    neg      = ifmap_s[DATA_W-1] ^ weight_s[DATA_W-1];
    ka       = lod(mag_a);
    kb       = lod(mag_b);
    ksum     = {1'b0, ka} + {1'b0, kb};
    fa       = mag_a & ~(MAG_W'(1) << ka);
    fb       = mag_b & ~(MAG_W'(1) << kb);
    s_term   = (P_W'(fa) << kb) + (P_W'(fb) << ka);
    t_term   = P_W'(1) << ksum;
    // Mitchell: below the carry point add the mantissa sum to T, else double it.
    p_full   = (s_term < t_term) ? (t_term + s_term) : (s_term << 1);
    p_mag    = p_full >> FRAC_W;
    prod_sat = ((mag_a == '0) || (mag_b == '0)) ? '0 : sat_prod(neg, p_mag);
  end

  // ---- stage p1: saturated partial sum, captured every cycle ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) psum_p1 <= '0;
    else        psum_p1 <= sat_add(ipsum_s, prod_sat);
  end

  assign bus.approx_P        = prod_sat;
  assign bus.approx_psum_reg = psum_p1;

endmodule

// File: tb/tb_pe_approx_sa.sv
// Randomised and directed bench for pe_approx_sa against an arithmetic model
// of the Mitchell multiplier with saturating accumulate.
module tb_pe_approx_sa;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [15:0] exp_reg;

  pe_approx_sa_if bus ();

  pe_approx_sa dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int model_p(input logic [15:0] x, input logic [15:0] w);
    longint a, b, ka, kb, fa, fb, s, t, p, r;
    a = x[15] ? (65536 - longint'(x)) : longint'(x);
    b = w[15] ? (65536 - longint'(w)) : longint'(w);
    if (a == 0 || b == 0) return 0;
    ka = $clog2(a + 1) - 1;
    kb = $clog2(b + 1) - 1;
    fa = a - (longint'(1) << ka);
    fb = b - (longint'(1) << kb);
    s  = fa * (longint'(1) << kb) + fb * (longint'(1) << ka);
    t  = longint'(1) << (ka + kb);
    p  = (s < t) ? (t + s) : (2 * s);
    r  = p / 256;
    if (x[15] ^ w[15]) r = -r;
    return clamp16(r);
  endfunction

  function automatic logic [15:0] model16(input logic [15:0] x, input logic [15:0] w);
    return 16'(model_p(x, w));
  endfunction

  function automatic logic [15:0] model_sum(input logic [15:0] ps, input logic [15:0] x,
                                            input logic [15:0] w);
    longint sum;
    sum = longint'($signed(ps)) + longint'(model_p(x, w));
    return 16'(clamp16(sum));
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
  endtask

  task automatic drive(input logic [15:0] x, input logic [15:0] w, input logic [15:0] ps);
    bus.ifmap  = x;
    bus.weight = w;
    bus.ipsum  = ps;
  endtask

  // Drive at current point, check product, then the captured sum after the edge.
  task automatic step(input string name, input logic [15:0] x, input logic [15:0] w,
                      input logic [15:0] ps, input logic [15:0] exp_p,
                      input logic [15:0] exp_r);
    drive(x, w, ps);
    #1;
    chk({name, "_P"}, bus.approx_P, exp_p);
    @(posedge clk);
    #1;
    chk({name, "_psum"}, bus.approx_psum_reg, exp_r);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] specials [8];
    specials = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0100, 16'hFF00,
                 16'h0001, 16'hFFFF, 16'h4000};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 7)];
    return 16'($urandom);
  endfunction

  // Expected registered sum: inputs at each live edge, cleared whenever reset drops.
  initial exp_reg = 16'h0000;
  always @(posedge clk) if (rst_n) exp_reg = model_sum(bus.ipsum, bus.ifmap, bus.weight);
  always @(negedge rst_n) exp_reg = 16'h0000;

  always @(negedge clk) begin
    chk("P_model",    bus.approx_P,        model16(bus.ifmap, bus.weight));
    chk("psum_model", bus.approx_psum_reg, exp_reg);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    drive(16'h0200, 16'h0300, 16'h0000);

    chk("model_pin_exact",  model16(16'h0200, 16'h0300), 16'h0600);
    chk("model_pin_approx", model16(16'h0180, 16'h0180), 16'h0200);
    chk("model_pin_satpos", model16(16'h030E, 16'h56AC), 16'h7FFF);
    chk("model_pin_satneg", model16(16'hFCF2, 16'h56AC), 16'h8000);

    #9;
    chk("reset_hold_psum", bus.approx_psum_reg, 16'h0000);
    chk("reset_hold_P",    bus.approx_P,        16'h0600);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_capture", bus.approx_psum_reg, 16'h0600);

    step("approx_branch", 16'h0180, 16'h0180, 16'h0100, 16'h0200, 16'h0300);
    step("neg_sign",      16'hFE00, 16'h0300, 16'h0000, 16'hFA00, 16'hFA00);
    step("zero_ifmap",    16'h0000, 16'h1234, 16'h0005, 16'h0000, 16'h0005);
    step("zero_weight",   16'h8000, 16'h0000, 16'hFFF0, 16'h0000, 16'hFFF0);
    step("sat_prod_pos",  16'h030E, 16'h56AC, 16'h0100, 16'h7FFF, 16'h7FFF);
    step("sat_prod_neg",  16'hFCF2, 16'h56AC, 16'hFF00, 16'h8000, 16'h8000);
    step("no_self_acc",   16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0100);
    step("min_x_min",     16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h7FFF);

    drive(16'h0200, 16'h0300, 16'h0100);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_reset_clear", bus.approx_psum_reg, 16'h0000);
    chk("mid_reset_P",     bus.approx_P,        16'h0600);
    @(posedge clk);
    #1;
    chk("reset_held_edge", bus.approx_psum_reg, 16'h0000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(16'h0180, 16'h0180, 16'h0100);
    @(posedge clk);
    #1;
    chk("release_capture", bus.approx_psum_reg, 16'h0300);

    for (int i = 0; i < 400; i++) begin
      drive(pick(), pick(), pick());
      if ($urandom_range(0, 39) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
